// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side word packer.
// Holds FIFO geometry, the packer state encoding and the output word width.
package fifo_pkg;

   localparam int DATA_WIDTH     = 8;
   localparam int ADDR_WIDTH     = 5;
   localparam int DEPTH          = 1 << ADDR_WIDTH;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_WIDTH     = DATA_WIDTH * BYTES_PER_WORD;

   typedef enum logic {
      FILL,
      OUT
   } packer_state_t;

   function automatic int word_width(input int dw, input int bpw);
      return dw * bpw;
   endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle counter for the word packer: counts consecutive idle cycles and
// pulses tmo on the TIMEOUT_CYCLES-th one. Ports: clk, rst, idle in; tmo out.
module packer_idle_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   output logic tmo
);

   import fifo_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] count;

   // Pulse on the last idle cycle so the flush lands exactly on the limit.
   assign tmo = idle && (count == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!idle || tmo) begin
         count <= '0;
      end else begin
         count <= count + TW'(1);
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from an 8-bit FIFO and packs them little-endian into words on a
// valid/ready port; partial words leave on flush (or idle timeout when
// PACKER_TIMEOUT_EN is defined).
// Ports: clk, rst, fifo_empty/fifo_rd/fifo_dout (FIFO read side), flush,
// word_data/word_be/word_valid/word_ready (output word handshake).
module fifo_word_packer #(
   parameter int DATA_WIDTH     = fifo_pkg::DATA_WIDTH,
   parameter int BYTES_PER_WORD = fifo_pkg::BYTES_PER_WORD,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 fifo_empty,
   output logic                                 fifo_rd,
   input  logic [DATA_WIDTH-1:0]                fifo_dout,
   input  logic                                 flush,
   output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_data,
   output logic [BYTES_PER_WORD-1:0]            word_be,
   output logic                                 word_valid,
   input  logic                                 word_ready
);

   import fifo_pkg::*;

   localparam int WW = word_width(DATA_WIDTH, BYTES_PER_WORD);
   localparam int CW = $clog2(BYTES_PER_WORD + 1);

   if (BYTES_PER_WORD < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("fifo_word_packer: unsupported parameter set");
   end

   packer_state_t                         state;
   logic [CW-1:0]                         cnt;
   logic                                  pend;
   logic                                  flush_pend;
   logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] lanes;

   logic [CW:0] fill;
   logic        full_now;
   logic        flush_req;
   logic        tmo;

   // Bytes already captured plus the one still in flight.
   assign fill     = {1'b0, cnt} + {{CW{1'b0}}, pend};
   assign full_now = pend && (fill == (CW+1)'(BYTES_PER_WORD));

   assign fifo_rd = (state == FILL) && !fifo_empty
                 && (fill < (CW+1)'(BYTES_PER_WORD)) && !flush_pend;

   assign word_data = WW'(lanes);

`ifdef PACKER_TIMEOUT_EN
   logic idle;

   assign idle = (state == FILL) && (cnt != '0) && !pend && fifo_empty;

   packer_idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .idle (idle),
      .tmo  (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   assign flush_req = flush | tmo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         cnt        <= '0;
         pend       <= 1'b0;
         flush_pend <= 1'b0;
         lanes      <= '0;
         word_be    <= '0;
         word_valid <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               pend <= fifo_rd;
               if (pend) begin
                  for (int i = 0; i < BYTES_PER_WORD; i++) begin
                     if (cnt == CW'(i)) begin
                        lanes[i]   <= fifo_dout;
                        word_be[i] <= 1'b1;
                     end
                  end
                  cnt <= cnt + CW'(1);
               end
               if (full_now || (!pend && flush_pend)) begin
                  state      <= OUT;
                  word_valid <= 1'b1;
               end else if (flush_req && (fill != '0)) begin
                  // A read issued this cycle must land before the word leaves.
                  if (!pend && !fifo_rd) begin
                     state      <= OUT;
                     word_valid <= 1'b1;
                  end else begin
                     flush_pend <= 1'b1;
                  end
               end
            end
            OUT: begin
               pend <= 1'b0;
               if (word_ready) begin
                  state      <= FILL;
                  word_valid <= 1'b0;
                  cnt        <= '0;
                  word_be    <= '0;
                  lanes      <= '0;
                  flush_pend <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
